// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter.
// Contents:
//   NumReq        number of requesters (fixed at 4)
//   DataWidth     width of one display value
//   CntWidth      width of the dwell counter
//   IdxWidth      width of a requester index
//   disp_state_e  arbiter FSM states (StIdle, StDwell)
//   onehot_to_idx encode a one-hot requester vector to its index
package disp_pkg;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned CntWidth  = 32;
  localparam int unsigned IdxWidth  = 2;

  typedef enum logic [0:0] {
    StIdle,
    StDwell
  } disp_state_e;

  function automatic logic [IdxWidth-1:0] onehot_to_idx(input logic [NumReq-1:0] oh);
    logic [IdxWidth-1:0] idx;
    idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (oh[i]) idx = IdxWidth'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin selector.
// Ports:
//   req_i    request vector
//   ptr_i    index searched first; search proceeds upward modulo 4
//   winner_o one-hot winner (all zero when no request)
//   valid_o  high when some request is set
module rr_arb4 import disp_pkg::*; (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   winner_o,
  output logic                valid_o
);

  logic [IdxWidth-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = 0; k < NumReq; k++) begin
      // Index arithmetic wraps naturally at IdxWidth bits.
      idx = ptr_i + IdxWidth'(k);
      if (!valid_o && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin arbiter feeding a seven-segment display scanner. A granted requester's value is
// captured and held for DWELL cycles; back-to-back grants follow with no idle gap.
// Optional feature: define DISP_ARB_PREEMPT_EN to let a rising req[0] preempt a dwell showing
// another requester.
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-requester level request
//   req_data     request values, requester i at [32i+31:32i]
//   grant        one-hot single-cycle capture acknowledge
//   data_to_show value currently displayed
//   src_id       index of the requester being shown
//   busy         high while a dwell period runs
module disp_arbiter import disp_pkg::*; #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned NUM_REQ = NumReq
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DataWidth-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [DataWidth-1:0]         data_to_show,
  output logic [IdxWidth-1:0]          src_id,
  output logic                         busy
);

  disp_state_e          state_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [IdxWidth-1:0]  ptr_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [DataWidth-1:0] data_q;
  logic [IdxWidth-1:0]  src_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   win;
  logic                 win_valid;
  logic [IdxWidth-1:0]  win_idx;
  logic                 dwell_end;
  logic                 sel;
  logic                 preempt;

  rr_arb4 u_rr_arb4 (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .valid_o  (win_valid)
  );

  assign win_idx   = onehot_to_idx(win);
  assign dwell_end = (cnt_q == CntWidth'(DWELL - 1));
  // A new winner is taken from idle, or on the last dwell cycle for a gap-free hand-over.
  assign sel       = win_valid && ((state_q == StIdle) || dwell_end);

`ifdef DISP_ARB_PREEMPT_EN
  logic req0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_q <= 1'b0;
    end else begin
      req0_q <= req[0];
    end
  end

  assign preempt = (state_q == StDwell) && req[0] && !req0_q && (src_q != '0);
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      src_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= '0;
      if (preempt) begin
        grant_q    <= NUM_REQ'(1);
        data_q     <= req_data[DataWidth-1:0];
        src_q      <= '0;
        cnt_q      <= '0;
        // Resume the rotation right after the requester that lost its slot.
        ptr_q      <= src_q + IdxWidth'(1);
      end else if (sel) begin
        state_q <= StDwell;
        grant_q <= win;
        data_q  <= req_data[win_idx*DataWidth +: DataWidth];
        src_q   <= win_idx;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        ptr_q   <= win_idx + IdxWidth'(1);
      end else if (state_q == StDwell) begin
        if (dwell_end) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntWidth'(1);
        end
      end
    end
  end

  assign grant        = grant_q;
  assign data_to_show = data_q;
  assign src_id       = src_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter with DWELL=4. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point.
module tb_disp_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   grant;
  logic [31:0]  data_to_show;
  logic [1:0]   src_id;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] vals [4];

  always #5 clk = ~clk;

  disp_arbiter #(
    .DWELL   (4),
    .NUM_REQ (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .data_to_show (data_to_show),
    .src_id       (src_id),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [31:0] d,
                         input logic [1:0] s, input logic b);
    chk({tag, " grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, " data"}, data_to_show, d);
    chk({tag, " src"}, {30'd0, src_id}, {30'd0, s});
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vals[0] = 32'h1111_1111;
    vals[1] = 32'h2222_2222;
    vals[2] = 32'h3333_3333;
    vals[3] = 32'h4444_4444;

    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = '0;
    #3;
    chk_out("reset", 4'b0000, 32'h0, 2'd0, 1'b0);
    tick;
    tick;

    // Single request, full dwell, then idle with data held.
    rst_n = 1'b1;
    req   = 4'b0001;
    req_data[31:0] = 32'h1234_5678;
    tick;
    chk_out("single grant", 4'b0001, 32'h1234_5678, 2'd0, 1'b1);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_out("single dwell", 4'b0000, 32'h1234_5678, 2'd0, 1'b1);
    end
    tick;
    chk_out("single idle", 4'b0000, 32'h1234_5678, 2'd0, 1'b0);

    // Reset again so the rotation restarts at index 0.
    rst_n = 1'b0;
    tick;
    chk_out("reset2", 4'b0000, 32'h0, 2'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = vals[i];
    req = 4'b1111;

    // All requesting: 0,1,2,3,0 back to back; last dwell also toggles the captured source.
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = k % 4;
      tick;
      chk_out("rr grant", 4'(1 << idx), vals[idx], 2'(idx), 1'b1);
      if (k == 4) req = 4'b0000;
      for (int j = 0; j < 3; j++) begin
        if (k == 4) req_data[31:0] = 32'hA5A5_0000 + 32'(j);
        tick;
        chk_out("rr dwell", 4'b0000, vals[idx], 2'(idx), 1'b1);
      end
    end
    tick;
    chk_out("hold idle", 4'b0000, vals[0], 2'd0, 1'b0);
    req_data[31:0] = vals[0];

    // Withdrawn request: req[2] pulsed during dwell of requester 1.
    req = 4'b0010;
    tick;
    chk_out("wd grant", 4'b0010, vals[1], 2'd1, 1'b1);
    req = 4'b0100;
    tick;
    chk_out("wd pulse", 4'b0000, vals[1], 2'd1, 1'b1);
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk_out("wd dwell", 4'b0000, vals[1], 2'd1, 1'b1);
    end
    tick;
    chk_out("wd idle", 4'b0000, vals[1], 2'd1, 1'b0);
    tick;
    chk_out("wd idle2", 4'b0000, vals[1], 2'd1, 1'b0);

    // Asynchronous reset mid-dwell at count 2.
    req = 4'b0001;
    tick;
    chk_out("ar grant", 4'b0001, vals[0], 2'd0, 1'b1);
    req = 4'b0000;
    tick;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar async", 4'b0000, 32'h0, 2'd0, 1'b0);
    req = 4'b0100;
    tick;
    chk_out("ar held", 4'b0000, 32'h0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick;
    chk_out("ar release", 4'b0100, vals[2], 2'd2, 1'b1);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) tick;
    tick;
    chk_out("ar idle", 4'b0000, vals[2], 2'd2, 1'b0);

    // req[0] rises while requester 2 is at dwell count 1; rotation pointer is now 3.
    req = 4'b0100;
    tick;
    chk_out("pe grant2", 4'b0100, vals[2], 2'd2, 1'b1);
    tick;
    chk_out("pe cnt1", 4'b0000, vals[2], 2'd2, 1'b1);
    req = 4'b0001;
    req_data[31:0] = 32'hDEAD_BEEF;
    tick;
`ifdef DISP_ARB_PREEMPT_EN
    chk_out("pe preempt", 4'b0001, 32'hDEAD_BEEF, 2'd0, 1'b1);
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_out("pe dwell", 4'b0000, 32'hDEAD_BEEF, 2'd0, 1'b1);
    end
    tick;
    chk_out("pe next", 4'b1000, vals[3], 2'd3, 1'b1);
`else
    chk_out("np hold", 4'b0000, vals[2], 2'd2, 1'b1);
    tick;
    chk_out("np dwell", 4'b0000, vals[2], 2'd2, 1'b1);
    tick;
    chk_out("np grant0", 4'b0001, 32'hDEAD_BEEF, 2'd0, 1'b1);
`endif
    req = 4'b0000;
    for (int i = 0; i < 3; i++) tick;
    tick;
    chk({"final busy"}, {31'd0, busy}, 32'd0);
    chk({"final grant"}, {28'd0, grant}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning the number of clk cycles a granted value is held on the display (legal range 1 to 2^32-1).
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (fixed at 4 in this revision).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester display request, level-sensitive.
REQ-006 req_data  input  128  request values; requester i occupies bits [32i+31:32i].
REQ-007 grant  output  4  one-hot, one-cycle pulse acknowledging capture of a requester's data.
REQ-008 data_to_show  output  32  value driven to the 8-digit seven-segment scanner.
REQ-009 src_id  output  2  index of the requester whose value is currently shown.
REQ-010 busy  output  1  high while a dwell period is running.

Function
REQ-011 SHALL implement states IDLE, DWELL; IDLE->DWELL on any req bit set; DWELL->DWELL (back-to-back) or DWELL->IDLE at dwell end, per REQ-015.
REQ-012 Arbitration SHALL be round-robin: search starts at the index after the last granted requester, modulo 4; after reset the search starts at index 0.
REQ-013 On the edge where a winner w is selected: data_to_show <= req_data[w], src_id <= w, grant <= one-hot(w) for exactly one cycle, busy <= 1, dwell counter <= 0.
REQ-014 Latency: req sampled high at edge N SHALL produce grant and new data_to_show valid after edge N (visible cycle N+1) when in IDLE.
REQ-015 Dwell counter SHALL increment each cycle in DWELL; at count DWELL-1: if any req set, arbitrate on the same edge (no idle gap); else go to IDLE, busy <= 0.
REQ-016 data_to_show and src_id SHALL hold their last values in IDLE (no blanking when empty).
REQ-017 req deasserted before grant SHALL be a withdrawn request and SHALL NOT be granted.
REQ-018 req still high after its grant SHALL be treated as a new request, served after the other pending requesters.
REQ-019 Changes on req_data outside the grant edge SHALL NOT affect data_to_show.
REQ-020 grant SHALL never have more than one bit set; grant SHALL be 0 in all cycles other than selection cycles.
REQ-021 Dwell counter SHALL be 32 bits, unsigned, and SHALL never wrap during a dwell.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, grant=0, data_to_show=0, src_id=0, busy=0, counter=0, and round-robin pointer so that index 0 is searched first.
REQ-023 Reset during DWELL SHALL abort the dwell; first arbitration after release SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-024 Macro DISP_ARB_PREEMPT_EN defined: req[0] rising while in DWELL showing src_id!=0 SHALL preempt on the next edge (grant[0], new data, counter restarts); the round-robin pointer SHALL then be restored to the preempted index + 1.
REQ-025 Macro undefined: no preemption; req[0] waits for dwell end like all other requesters.

Structure
REQ-026 Shared package disp_pkg SHALL hold the state enum (IDLE, DWELL), NUM_REQ, the data width constant 32 and the counter width constant 32.
REQ-027 Round-robin selection SHALL be a sub-module rr_arb4 (inputs req, pointer; outputs one-hot winner and valid), purely combinational; all registers remain in disp_arbiter.

Verification
REQ-028 Reset then req=4'b0001, req_data[31:0]=32'h1234_5678 -> next cycle grant=0001, data_to_show=12345678, src_id=0, busy=1 for 4 cycles, then IDLE with data held.
REQ-029 req=4'b1111 held, DWELL=4 -> grants 0,1,2,3,0 at 4-cycle spacing with no idle cycle; data_to_show follows each requester's value.
REQ-030 req[2] pulsed high 1 cycle during dwell of src 1 then dropped -> req[2] never granted; IDLE after dwell.
REQ-031 rst_n low mid-dwell (counter=2) -> all outputs 0 asynchronously; after release with req=4'b0100 -> grant=0100 next edge.
REQ-032 DISP_ARB_PREEMPT_EN, src 2 in dwell at count 1, req[0] rises with value 32'hDEAD_BEEF -> next edge grant=0001, data_to_show=DEADBEEF, counter 0; next round-robin grant is index 3.
REQ-033 req_data of the granted requester toggles each cycle during dwell -> data_to_show stays at the captured value.
